// File: rtl/mu0_alu_reg.sv
// mu0_alu_reg: registered ALU for the MU0 16-bit accumulator datapath.
// Serves both PC increment / address passthrough during fetch and ACC
// arithmetic during execute. One operation per enabled clock edge; result
// and status flags are registered and appear one cycle after the operands.
//
// Ports:
//   Clk   - rising-edge clock
//   Reset - asynchronous active-high reset; clears Q/N/C/V and sets Z
//   En    - load enable; Q and flags update only when high at the edge
//   X     - operand A (ACC or PC)
//   Y     - operand B (memory data or instruction operand)
//   M     - op select: 00 pass Y, 01 X+Y, 10 X+1, 11 X-Y
//   Q     - registered result
//   N,Z   - negative / zero flags of Q
//   C,V   - carry-out / signed overflow of the registered operation
module mu0_alu_reg #(
    parameter int WIDTH = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             En,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic [1:0]       M,
    output logic [WIDTH-1:0] Q,
    output logic             N,
    output logic             Z,
    output logic             C,
    output logic             V
);

    typedef enum logic [1:0] {
        OP_PASS = 2'b00,
        OP_ADD  = 2'b01,
        OP_INC  = 2'b10,
        OP_SUB  = 2'b11
    } op_t;

    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic             cin;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             ovf;

    // Single shared adder; INC and SUB are folded in through the B operand
    // and the carry-in (SUB computes X + ~Y + 1).
    always_comb begin
        opa = X;
        opb = '0;
        cin = 1'b0;
        case (op_t'(M))
            OP_ADD: opb = Y;
            OP_INC: cin = 1'b1;
            OP_SUB: begin
                opb = ~Y;
                cin = 1'b1;
            end
            default: ;
        endcase
    end

    assign sum = {1'b0, opa} + {1'b0, opb} + {{WIDTH{1'b0}}, cin};

    always_comb begin
        if (op_t'(M) == OP_PASS) begin
            result = Y;
            carry  = 1'b0;
            ovf    = 1'b0;
        end else begin
            result = sum[WIDTH-1:0];
            carry  = sum[WIDTH];
            // Overflow: like-signed operands produced a result of the other sign.
            ovf    = (opa[WIDTH-1] == opb[WIDTH-1]) &&
                     (result[WIDTH-1] != opa[WIDTH-1]);
        end
    end

    // N and Z come from the value being captured so they always track Q.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            Q <= '0;
            N <= 1'b0;
            Z <= 1'b1;
            C <= 1'b0;
            V <= 1'b0;
        end else if (En) begin
            Q <= result;
            N <= result[WIDTH-1];
            Z <= (result == '0);
            C <= carry;
            V <= ovf;
        end
    end

endmodule

// File: tb/tb_mu0_alu_reg.sv
module tb_mu0_alu_reg;

    logic        Clk;
    logic        Reset;
    logic        En;
    logic [15:0] X;
    logic [15:0] Y;
    logic [1:0]  M;
    logic [15:0] Q;
    logic        N;
    logic        Z;
    logic        C;
    logic        V;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [19:0] expv;
        int          idx;
    } exp_t;

    exp_t        exp_q[$];
    logic [19:0] model;   // {Q, N, Z, C, V}
    int          op_idx = 0;

    localparam logic [19:0] RESET_VAL = {16'h0000, 1'b0, 1'b1, 1'b0, 1'b0};

    mu0_alu_reg #(.WIDTH(16)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .En    (En),
        .X     (X),
        .Y     (Y),
        .M     (M),
        .Q     (Q),
        .N     (N),
        .Z     (Z),
        .C     (C),
        .V     (V)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Reference: plain integer arithmetic on unsigned and signed views.
    function automatic logic [19:0] ref_op(input logic [1:0] m, input logic [15:0] x,
                                           input logic [15:0] y);
        int          ux;
        int          uy;
        int          sx;
        int          sy;
        int          full;
        int          sres;
        logic [15:0] r;
        logic        c;
        logic        v;
        ux = int'(x);
        uy = int'(y);
        sx = int'($signed(x));
        sy = int'($signed(y));
        r  = 16'h0;
        c  = 1'b0;
        v  = 1'b0;
        case (m)
            2'b00: r = y;
            2'b01: begin
                full = ux + uy;
                sres = sx + sy;
                r = 16'(full);
                c = (full > 65535);
                v = (sres > 32767) || (sres < -32768);
            end
            2'b10: begin
                full = ux + 1;
                sres = sx + 1;
                r = 16'(full);
                c = (full > 65535);
                v = (sres > 32767);
            end
            default: begin
                full = ux - uy;
                sres = sx - sy;
                r = 16'(full);
                c = (ux >= uy);
                v = (sres > 32767) || (sres < -32768);
            end
        endcase
        return {r, r[15], (r == 16'h0), c, v};
    endfunction

    task automatic check(input string name, input logic [19:0] got, input logic [19:0] expv);
        checks++;
        if (got !== expv) begin
            failures++;
            $display("FAIL %s: got Q=%h N=%b Z=%b C=%b V=%b, want Q=%h N=%b Z=%b C=%b V=%b",
                     name, got[19:4], got[3], got[2], got[1], got[0],
                     expv[19:4], expv[3], expv[2], expv[1], expv[0]);
        end
    endtask

    // Drive one operation, let the edge capture it, then post the expectation.
    task automatic apply(input logic en, input logic [1:0] m, input logic [15:0] x,
                         input logic [15:0] y);
        exp_t e;
        En = en;
        M  = m;
        X  = x;
        Y  = y;
        if (en) model = ref_op(m, x, y);
        @(posedge Clk);
        e.expv = model;
        e.idx  = op_idx;
        op_idx++;
        exp_q.push_back(e);
        #1;
    endtask

    // Monitor: every presented result is compared on the falling edge.
    always @(negedge Clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check($sformatf("op%0d", e.idx), {Q, N, Z, C, V}, e.expv);
        end
    end

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 20) begin
            @(posedge Clk);
            n++;
        end
        @(negedge Clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        Reset = 1'b1;
        En    = 1'b0;
        M     = 2'b00;
        X     = 16'h0;
        Y     = 16'h0;
        model = RESET_VAL;

        #2;
        check("reset_state", {Q, N, Z, C, V}, RESET_VAL);
        En = 1'b1;
        M  = 2'b01;
        X  = 16'h1234;
        Y  = 16'h1111;
        @(posedge Clk);
        #1;
        check("reset_hold_start", {Q, N, Z, C, V}, RESET_VAL);
        Reset = 1'b0;

        // Directed boundary cases.
        apply(1'b1, 2'b00, 16'h0001, 16'hF001);
        apply(1'b1, 2'b00, 16'h0000, 16'h00FE);
        apply(1'b1, 2'b10, 16'hFFFF, 16'h1234);
        apply(1'b1, 2'b10, 16'h7FFF, 16'h0000);
        apply(1'b1, 2'b01, 16'hE001, 16'h1FFF);
        apply(1'b1, 2'b01, 16'h8000, 16'h8000);
        apply(1'b1, 2'b11, 16'h000A, 16'h000A);
        apply(1'b1, 2'b11, 16'h0001, 16'h0002);
        apply(1'b1, 2'b11, 16'h0FFF, 16'h000F);
        apply(1'b1, 2'b01, 16'h7FFF, 16'h0001);
        apply(1'b0, 2'b11, 16'h0001, 16'h0002);
        apply(1'b0, 2'b00, 16'h5555, 16'h0000);
        apply(1'b0, 2'b10, 16'hFFFF, 16'hAAAA);
        apply(1'b1, 2'b00, 16'h0000, 16'h1357);

        // Randomized traffic, back to back, with occasional holds.
        for (int i = 0; i < 400; i++) begin
            logic [15:0] rx;
            logic [15:0] ry;
            rx = 16'($urandom);
            ry = 16'($urandom);
            if ($urandom_range(0, 7) == 0) rx = 16'h7FFF;
            if ($urandom_range(0, 7) == 0) ry = 16'h8000;
            if ($urandom_range(0, 9) == 0) ry = rx;
            apply($urandom_range(0, 4) != 0, 2'($urandom_range(0, 3)), rx, ry);
        end
        drain();

        // Asynchronous reset mid-cycle with an add pending.
        apply(1'b1, 2'b01, 16'h1234, 16'h4321);
        drain();
        En = 1'b1;
        M  = 2'b01;
        X  = 16'h7FFF;
        Y  = 16'h0001;
        Reset = 1'b1;
        #1;
        check("reset_async", {Q, N, Z, C, V}, RESET_VAL);
        for (int i = 0; i < 2; i++) begin
            @(posedge Clk);
            #1;
            check("reset_hold", {Q, N, Z, C, V}, RESET_VAL);
        end
        Reset = 1'b0;
        model = RESET_VAL;
        apply(1'b0, 2'b01, 16'h7FFF, 16'h0001);
        apply(1'b1, 2'b11, 16'h0000, 16'h0001);
        apply(1'b1, 2'b10, 16'h8000, 16'h0000);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit, want completion");
        $fatal(1, "timeout");
    end

endmodule
